ahb_master_arbiter: RTL and testbench
=====================================

// Module: ahb_master_arbiter
// PURPOSE
//  Shares one AHB-Lite master port (PLIC register-access bus) among NUM_REQ
//  single-transfer requesters. Round-robin grant; sequences each transfer
//  through address and data phases; returns read data and error per requester.
//  One transfer outstanding at a time. No bursts. Sits between the test/CPU
//  request sources and the AHB slave side of the PLIC.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  TIMEOUT  16  data-phase wait cycles (h_ready_out low) before forced error
// PORTS
//  h_clk        in   1          bus clock
//  h_reset_n    in   1          async active-low reset
//  req_valid    in   NUM_REQ    request pending; held until req_ready
//  req_write    in   NUM_REQ    1=write 0=read
//  req_addr     in   NUM_REQ*32 byte address (slice i = requester i)
//  req_wdata    in   NUM_REQ*32 write data
//  req_size     in   NUM_REQ*3  HSIZE encoding: 0=byte, 1=half, 2=word
//  req_ready    out  NUM_REQ    one-hot accept pulse
//  rsp_valid    out  NUM_REQ    one-hot 1-cycle completion pulse
//  rsp_rdata    out  32         read data, valid with rsp_valid
//  rsp_err      out  1          error flag, valid with rsp_valid
//  h_addr       out  32         AHB address
//  h_burst      out  3          tied 3'b000 (SINGLE)
//  h_size       out  3          AHB size
//  h_trans      out  2          IDLE=2'b00, NONSEQ=2'b10
//  h_write      out  1          AHB write
//  h_wdata      out  32         AHB write data (data phase)
//  h_prot       out  4          tied 4'b0011
//  h_sel_0      out  1          slave select, high in ADDR state only
//  h_ready      out  1          HREADY to slave = h_ready_out
//  h_rdata      in   32         slave read data
//  h_ready_out  in   1          slave ready
//  h_resp       in   1          slave response: 0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset (async): state=IDLE; rr pointer=NUM_REQ-1 (requester 0 wins first);
//   timeout cnt=0; all outputs 0 except h_burst=0, h_prot=4'b0011,
//   h_ready=h_ready_out.
//  FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//   IDLE: grant g = first valid requester scanning from ptr+1, mod NUM_REQ.
//    req_ready[g]=1 (combinational, same cycle). Edge: latch addr/write/
//    wdata/size; ptr<=g. Misaligned request (size 1 & addr[0], or size 2 &
//    addr[1:0]!=0) or size>2 -> RESP with err=1, no bus cycle. Else -> ADDR.
//   ADDR: h_trans=NONSEQ, h_sel_0=1, h_addr/h_write/h_size from latch.
//    h_ready_out=1 at edge -> DATA. Else hold all outputs.
//   DATA: h_trans=IDLE, h_sel_0=0, h_wdata=latched wdata (writes).
//    h_ready_out=1 at edge: capture h_rdata (reads only, else 0) and h_resp
//    -> RESP; cnt<=0.
//    h_ready_out=0: cnt++. cnt==TIMEOUT-1 at an edge -> RESP, err=1.
//    Two-cycle ERROR (h_resp=1, h_ready_out=0): stay in DATA. Error is
//    captured on the ready-high cycle.
//   RESP: rsp_valid[g]=1 for 1 cycle with rsp_rdata/rsp_err -> IDLE.
//  Latency: accept edge to rsp_valid = 3 cycles with zero waits (1 for
//   misaligned); +1 per wait state.
//  No request is accepted outside IDLE. req_valid changes on non-granted
//   requesters while busy do not matter. Back-to-back: the next grant
//   occurs in the IDLE cycle after RESP.
//  A single requester gets consecutive grants when it is the only one
//   valid. Under contention, grants strictly alternate.
//  Reset mid-transfer: abort immediately with no rsp_valid. The bus
//   returns to IDLE.
// TESTING
//  1 Req0 write 0x0C00_0004 = 0xA5A5_0001, zero-wait slave -> one NONSEQ
//    cycle, h_wdata=0xA5A5_0001 next cycle, rsp_valid[0] 3 cycles after accept,
//    rsp_err=0.
//  2 Req0+req1 valid together, 4 back-to-back each -> grants 0,1,0,1...
//    First grant goes to 0 after reset. h_trans never NONSEQ twice
//    without a data phase.
//  3 Read 0x0C20_0004 with 3 wait states, h_rdata=0x0000_0007 ->
//    rsp_rdata=7, rsp_valid 6 cycles after accept.
//  4 Slave two-cycle ERROR response on a write -> rsp_err=1,
//    rsp_valid[g] single pulse.
//  5 Word read at 0x0C00_0002 -> rsp_err=1 one cycle after accept,
//    h_sel_0 never asserted. Slave holds h_ready_out=0 -> err after
//    TIMEOUT=16 cycles.
//  6 Assert h_reset_n=0 during DATA -> all outputs at reset values
//    asynchronously, no rsp_valid. Next request is granted normally.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// AHB-Lite single-master arbiter for the PLIC register bus.
// NUM_REQ single-transfer requesters share one AHB master port under
// round-robin arbitration. One transfer is in flight at a time.

// Per-requester handshake decode: turns the shared grant index into this
// requester's accept pulse and completion pulse.
module ahb_arb_lane #(
  parameter int PW  = 1,
  parameter int IDX = 0
) (
  input  logic [PW-1:0] acc_sel,
  input  logic          acc_en,
  input  logic [PW-1:0] rsp_sel,
  input  logic          rsp_en,
  output logic          ready,
  output logic          valid
);
  assign ready = acc_en & (acc_sel == PW'(IDX));
  assign valid = rsp_en & (rsp_sel == PW'(IDX));
endmodule

module ahb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   h_clk,
  input  logic                   h_reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*3-1:0]   req_size,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [31:0]            h_addr,
  output logic [2:0]             h_burst,
  output logic [2:0]             h_size,
  output logic [1:0]             h_trans,
  output logic                   h_write,
  output logic [31:0]            h_wdata,
  output logic [3:0]             h_prot,
  output logic                   h_sel_0,
  output logic                   h_ready,
  input  logic [31:0]            h_rdata,
  input  logic                   h_ready_out,
  input  logic                   h_resp
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t        state, nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] gnt_next;
  logic          any_req;
  logic          accept;
  logic          bad;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic [31:0]   sel_addr;
  logic [2:0]    sel_size;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [2:0]    lat_size;
  logic          lat_write;
  logic [31:0]   rdata_q;
  logic          err_q;

  // Round-robin: first valid requester scanning upward from ptr+1.
  always_comb begin
    int idx;
    idx      = 0;
    any_req  = 1'b0;
    gnt_next = ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req  = 1'b1;
        gnt_next = PW'(idx);
      end
    end
  end

  assign sel_addr = req_addr[int'(gnt_next)*32 +: 32];
  assign sel_size = req_size[int'(gnt_next)*3 +: 3];

  // Unsupported size or misaligned address completes with error, no bus cycle.
  assign bad = (sel_size > 3'd2) ||
               ((sel_size == 3'd1) && sel_addr[0]) ||
               ((sel_size == 3'd2) && (sel_addr[1:0] != 2'b00));

  // Reset gates the accept so req_ready stays low while reset is held.
  assign accept   = (state == S_IDLE) && any_req && h_reset_n;
  assign cnt_last = (cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) state <= S_IDLE;
    else            state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (accept) nxt = bad ? S_RESP : S_ADDR;
      S_ADDR: if (h_ready_out) nxt = S_DATA;
      S_DATA: if (h_ready_out || cnt_last) nxt = S_RESP;
      S_RESP: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Request latch, round-robin pointer, wait counter and response capture.
  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      ptr       <= PW'(NUM_REQ - 1);
      gnt       <= '0;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
      lat_write <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          lat_addr  <= sel_addr;
          lat_wdata <= req_wdata[int'(gnt_next)*32 +: 32];
          lat_size  <= sel_size;
          lat_write <= req_write[gnt_next];
          gnt       <= gnt_next;
          ptr       <= gnt_next;
          cnt       <= '0;
          rdata_q   <= '0;
          err_q     <= bad;
        end
        S_DATA: begin
          if (h_ready_out) begin
            // A two-cycle ERROR is taken from its ready-high cycle.
            rdata_q <= lat_write ? 32'h0 : h_rdata;
            err_q   <= h_resp;
            cnt     <= '0;
          end else if (cnt_last) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus and response outputs, decoded from state only.
  always_comb begin
    h_trans   = TRANS_IDLE;
    h_sel_0   = 1'b0;
    h_addr    = '0;
    h_write   = 1'b0;
    h_size    = '0;
    h_wdata   = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      S_ADDR: begin
        h_trans = TRANS_NONSEQ;
        h_sel_0 = 1'b1;
        h_addr  = lat_addr;
        h_write = lat_write;
        h_size  = lat_size;
      end
      S_DATA: h_wdata = lat_write ? lat_wdata : 32'h0;
      S_RESP: begin
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign h_burst = 3'b000;
  assign h_prot  = 4'b0011;
  assign h_ready = h_ready_out;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    ahb_arb_lane #(.PW(PW), .IDX(i)) u_lane (
      .acc_sel (gnt_next),
      .acc_en  (accept),
      .rsp_sel (gnt),
      .rsp_en  (state == S_RESP),
      .ready   (req_ready[i]),
      .valid   (rsp_valid[i])
    );
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: requests are issued in sequence,
// expected completions are queued at issue and matched as rsp_valid arrives.
module tb_ahb_master_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;

  logic                  h_clk;
  logic                  h_reset_n;
  logic [NUM_REQ-1:0]    req_valid, req_write;
  logic [NUM_REQ*32-1:0] req_addr, req_wdata;
  logic [NUM_REQ*3-1:0]  req_size;
  logic [NUM_REQ-1:0]    req_ready, rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [31:0]           h_addr, h_wdata, h_rdata;
  logic [2:0]            h_burst, h_size;
  logic [1:0]            h_trans;
  logic                  h_write, h_sel_0, h_ready, h_ready_out, h_resp;
  logic [3:0]            h_prot;

  ahb_master_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .h_clk(h_clk), .h_reset_n(h_reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .h_addr(h_addr), .h_burst(h_burst), .h_size(h_size), .h_trans(h_trans),
    .h_write(h_write), .h_wdata(h_wdata), .h_prot(h_prot), .h_sel_0(h_sel_0),
    .h_ready(h_ready), .h_rdata(h_rdata), .h_ready_out(h_ready_out),
    .h_resp(h_resp)
  );

  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   nonseq_n = 0;
  int   sel_n = 0;

  // Slave behaviour knobs, set by the main sequence.
  int          slv_waits = 0;
  bit          slv_err = 0;
  bit          slv_hang = 0;
  logic [31:0] slv_rdata = 32'h0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(int idx, logic [31:0] rd, logic err, int lat);
    exp_t e;
    e.idx = idx; e.rdata = rd; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic set_req(int r, bit wr, logic [31:0] a, logic [31:0] d, logic [2:0] sz);
    req_write[r]          = wr;
    req_addr[r*32 +: 32]  = a;
    req_wdata[r*32 +: 32] = d;
    req_size[r*3 +: 3]    = sz;
    req_valid[r]          = 1'b1;
  endtask

  // Wait for the accept pulse, check it went to requester r, then drop r's valid.
  task automatic wait_accept(int r);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge h_clk);
      if (req_ready != '0) begin
        seen = 1;
        check("grant", 32'(req_ready), 32'(1 << r));
      end
    end
    if (!seen) check("accept_timeout", 32'(req_ready), 32'(1 << r));
    @(posedge h_clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge h_clk);
    if (sb.size() != 0) check("rsp_timeout", 32'(sb.size()), 32'd0);
    @(posedge h_clk); #1;
  endtask

  // Slave: decides h_ready_out/h_resp/h_rdata for each data-phase cycle.
  initial begin
    int w;
    bit in_data;
    bit start;
    w = 0; in_data = 0;
    h_ready_out = 1'b1; h_resp = 1'b0; h_rdata = 32'h0;
    forever begin
      @(negedge h_clk);
      start = (h_trans == 2'b10) && h_sel_0 && h_ready_out;
      @(posedge h_clk); #1;
      if (!h_reset_n) begin
        in_data = 0; start = 0;
      end
      if (start) begin in_data = 1; w = slv_waits; end
      if (in_data) begin
        if (slv_hang || w > 0) begin
          h_ready_out = 1'b0;
          h_resp      = slv_err && !slv_hang && (w == 1);
          if (w > 0) w--;
        end else begin
          h_ready_out = 1'b1; h_resp = slv_err; h_rdata = slv_rdata;
          in_data = 0;
        end
      end else begin
        h_ready_out = 1'b1; h_resp = 1'b0; h_rdata = 32'h0;
      end
    end
  end

  // Monitor: counts bus activity and matches completions to the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge h_clk);
      cyc++;
      if (h_trans == 2'b10) nonseq_n++;
      if (h_sel_0) sel_n++;
      if (req_ready != '0) acc_cyc = cyc;
      if (rsp_valid != '0) begin
        if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, s0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_size = '0;
    h_reset_n = 1'b0;
    #1;
    check("rst_h_trans", 32'(h_trans), 32'd0);
    check("rst_h_sel_0", 32'(h_sel_0), 32'd0);
    check("rst_h_prot", 32'(h_prot), 32'h3);
    check("rst_h_burst", 32'(h_burst), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_h_ready", 32'(h_ready), 32'(h_ready_out));
    repeat (3) @(posedge h_clk);
    #1 h_reset_n = 1'b1;
    repeat (2) @(posedge h_clk);
    #1;

    // Contention: both requesters, four writes each, must alternate from 0.
    n0 = nonseq_n;
    set_req(0, 1, 32'h0C00_0000, 32'h1000_0000, 3'd2);
    set_req(1, 1, 32'h0C00_0100, 32'h2000_0000, 3'd2);
    for (int k = 0; k < 8; k++) begin
      exp_push(k % 2, 32'h0, 1'b0, 3);
      wait_accept(k % 2);
      if (k < 6)
        set_req(k % 2, 1, 32'h0C00_0000 + 32'(k * 4), 32'h3000_0000 + 32'(k), 3'd2);
    end
    wait_idle();
    check("rr_nonseq_count", 32'(nonseq_n - n0), 32'd8);

    // Zero-wait write from requester 0 with phase-by-phase bus checks.
    exp_push(0, 32'h0, 1'b0, 3);
    set_req(0, 1, 32'h0C00_0004, 32'hA5A5_0001, 3'd2);
    wait_accept(0);
    @(negedge h_clk);
    check("addr_h_trans", 32'(h_trans), 32'h2);
    check("addr_h_addr", h_addr, 32'h0C00_0004);
    check("addr_h_write", 32'(h_write), 32'd1);
    check("addr_h_size", 32'(h_size), 32'd2);
    check("addr_h_sel_0", 32'(h_sel_0), 32'd1);
    @(negedge h_clk);
    check("data_h_trans", 32'(h_trans), 32'd0);
    check("data_h_sel_0", 32'(h_sel_0), 32'd0);
    check("data_h_wdata", h_wdata, 32'hA5A5_0001);
    wait_idle();

    // Read with three wait states.
    slv_waits = 3; slv_rdata = 32'h0000_0007;
    exp_push(1, 32'h7, 1'b0, 6);
    set_req(1, 0, 32'h0C20_0004, 32'h0, 3'd2);
    wait_accept(1);
    wait_idle();

    // Two-cycle ERROR response on a write.
    slv_waits = 1; slv_err = 1; slv_rdata = 32'h0;
    exp_push(0, 32'h0, 1'b1, 4);
    set_req(0, 1, 32'h0C00_0008, 32'hCAFE_0000, 3'd2);
    wait_accept(0);
    wait_idle();
    slv_waits = 0; slv_err = 0;

    // Misaligned word read: immediate error, no bus cycle.
    n0 = nonseq_n; s0 = sel_n;
    exp_push(1, 32'h0, 1'b1, 1);
    set_req(1, 0, 32'h0C00_0002, 32'h0, 3'd2);
    wait_accept(1);
    wait_idle();
    check("misalign_no_sel", 32'(sel_n - s0), 32'd0);
    check("misalign_no_nonseq", 32'(nonseq_n - n0), 32'd0);

    // Misaligned halfword and illegal size.
    exp_push(0, 32'h0, 1'b1, 1);
    set_req(0, 0, 32'h0C00_0001, 32'h0, 3'd1);
    wait_accept(0);
    wait_idle();
    exp_push(1, 32'h0, 1'b1, 1);
    set_req(1, 0, 32'h0C00_0000, 32'h0, 3'd3);
    wait_accept(1);
    wait_idle();

    // Slave never ready: forced error after TIMEOUT data-phase cycles.
    slv_hang = 1; slv_rdata = 32'hFFFF_FFFF;
    exp_push(0, 32'h0, 1'b1, 2 + TIMEOUT);
    set_req(0, 0, 32'h0C00_000C, 32'h0, 3'd2);
    wait_accept(0);
    wait_idle();
    slv_hang = 0; slv_rdata = 32'h0;
    repeat (2) @(posedge h_clk);
    #1;

    // Reset during the data phase: outputs drop at once, no completion.
    slv_waits = 4;
    set_req(1, 1, 32'h0C00_0010, 32'hDEAD_BEEF, 3'd2);
    wait_accept(1);
    @(negedge h_clk);
    @(negedge h_clk);
    check("pre_rst_h_wdata", h_wdata, 32'hDEAD_BEEF);
    #2 h_reset_n = 1'b0;
    #1;
    check("async_h_wdata", h_wdata, 32'h0);
    check("async_h_trans", 32'(h_trans), 32'd0);
    check("async_h_sel_0", 32'(h_sel_0), 32'd0);
    check("async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_h_prot", 32'(h_prot), 32'h3);
    slv_waits = 0;
    repeat (2) @(posedge h_clk);
    #1 h_reset_n = 1'b1;
    repeat (3) @(posedge h_clk);
    #1;

    // Normal operation after reset; pointer reset makes 0 win over 1.
    slv_rdata = 32'h0000_0055;
    exp_push(0, 32'h55, 1'b0, 3);
    exp_push(1, 32'h55, 1'b0, 3);
    set_req(0, 0, 32'h0C00_0020, 32'h0, 3'd2);
    set_req(1, 0, 32'h0C00_0024, 32'h0, 3'd2);
    wait_accept(0);
    wait_accept(1);
    wait_idle();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
